// File: rtl/dino_pkg.sv
// Shared types and widths for the dinosaur game blocks.
// The game state enum is shared with the Ground and score-display blocks.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int SPEED_W    = 4;
    localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/bcd4_counter.sv
// Packed-BCD up counter with synchronous clear and increment enable.
// The hundred_roll flag is combinational so the caller can act on it in the same edge as the increment.
module bcd4_counter
    import dino_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    inc,
    output logic [4*BCD_DIGITS-1:0] value,
    output logic                    hundred_roll
);

    logic [4*BCD_DIGITS-1:0] next_value;
    logic                    carry;

    // Ripple the +1 through the digits; a 9 becomes 0 and passes the carry on.
    always_comb begin
        next_value = value;
        carry      = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    next_value[4*i +: 4] = 4'd0;
                end else begin
                    next_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    assign hundred_roll = inc && (value[7:0] == 8'h99);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Dinosaur game sequencer: IDLE/RUN/CRASH/OVER, scroll strobe per frame,
// BCD score and high score, speed ramp every 100 points.
module game_ctrl
    import dino_pkg::*;
#(
    parameter int SCORE_DIV  = 6,
    parameter int SPEED_MIN  = 1,
    parameter int SPEED_MAX  = 15,
    parameter int CRASH_HOLD = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         collision,
    output logic         game_status,
    output logic [3:0]   speed,
    output logic         scroll_pulse,
    output logic         crashed,
    output logic [15:0]  score,
    output logic [15:0]  hi_score,
    output logic [1:0]   dbg_state
);

    localparam int DIV_W  = $clog2(SCORE_DIV + 1);
    localparam int HOLD_W = $clog2(CRASH_HOLD + 1);

    game_state_t         state;
    logic [DIV_W-1:0]    div_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                score_clear;
    logic                score_inc;
    logic                hundred_roll;

    // Collision wins over a frame tick in the same cycle, so it gates the increment.
    assign score_inc   = (state == RUN) && !collision && frame_tick &&
                         (div_cnt == DIV_W'(SCORE_DIV - 1));
    assign score_clear = (state == IDLE) || ((state == OVER) && start);
    assign dbg_state   = state;

    bcd4_counter u_score (
        .clk          (clk),
        .rst          (rst),
        .clear        (score_clear),
        .inc          (score_inc),
        .value        (score),
        .hundred_roll (hundred_roll)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            game_status  <= 1'b0;
            crashed      <= 1'b0;
            scroll_pulse <= 1'b0;
            speed        <= SPEED_W'(SPEED_MIN);
            hi_score     <= '0;
            div_cnt      <= '0;
            hold_cnt     <= '0;
        end else begin
            scroll_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    hold_cnt <= '0;
                    speed    <= SPEED_W'(SPEED_MIN);
                    if (start) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                    end
                end
                RUN: begin
                    if (collision) begin
                        state       <= CRASH;
                        game_status <= 1'b0;
                        crashed     <= 1'b1;
                        hold_cnt    <= '0;
                        // Score cannot change on a collision cycle, so the current value is final.
                        if (score > hi_score) hi_score <= score;
                    end else if (frame_tick) begin
                        scroll_pulse <= 1'b1;
                        if (div_cnt == DIV_W'(SCORE_DIV - 1)) div_cnt <= '0;
                        else                                  div_cnt <= div_cnt + 1'b1;
                        if (hundred_roll && (speed != SPEED_W'(SPEED_MAX)))
                            speed <= speed + 1'b1;
                    end
                end
                CRASH: begin
                    if (frame_tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_W'(CRASH_HOLD - 1)) state <= OVER;
                    end
                end
                OVER: begin
                    if (start) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                        crashed     <= 1'b0;
                        div_cnt     <= '0;
                        speed       <= SPEED_W'(SPEED_MIN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a default-parameter instance and a fast one (SCORE_DIV=1, CRASH_HOLD=4)
// share stimulus and are each checked every cycle against an integer-arithmetic game model.
module tb_game_ctrl;
    import dino_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start, frame_tick, collision;
    always #5 clk = ~clk;

    logic [1:0]  gs, cr, sp;
    logic [3:0]  spd [2];
    logic [15:0] sc  [2];
    logic [15:0] hi  [2];
    logic [1:0]  st  [2];

    game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .collision(collision),
        .game_status(gs[0]), .speed(spd[0]), .scroll_pulse(sp[0]), .crashed(cr[0]),
        .score(sc[0]), .hi_score(hi[0]), .dbg_state(st[0])
    );

    game_ctrl #(.SCORE_DIV(1), .CRASH_HOLD(4)) dut_fast (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .collision(collision),
        .game_status(gs[1]), .speed(spd[1]), .scroll_pulse(sp[1]), .crashed(cr[1]),
        .score(sc[1]), .hi_score(hi[1]), .dbg_state(st[1])
    );

    int errors = 0;
    int checks = 0;
    int scroll_cnt0 = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          div_p  [2] = '{6, 1};
    int          hold_p [2] = '{60, 4};
    game_state_t m_st    [2];
    int          m_score [2], m_hi [2], m_div [2], m_hold [2], m_speed [2];
    logic        m_scroll[2];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = IDLE; m_score[k] = 0; m_hi[k] = 0; m_div[k] = 0;
                m_hold[k] = 0; m_speed[k] = 1; m_scroll[k] = 1'b0;
            end else begin
                m_scroll[k] = 1'b0;
                case (m_st[k])
                    IDLE: begin
                        m_score[k] = 0; m_speed[k] = 1; m_div[k] = 0;
                        if (start) m_st[k] = RUN;
                    end
                    RUN: begin
                        if (collision) begin
                            m_st[k] = CRASH; m_hold[k] = 0;
                            if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
                        end else if (frame_tick) begin
                            m_scroll[k] = 1'b1;
                            m_div[k]++;
                            if (m_div[k] == div_p[k]) begin
                                m_div[k] = 0;
                                m_score[k] = (m_score[k] + 1) % 10000;
                                if (m_score[k] % 100 == 0) m_speed[k] = (m_speed[k] < 15) ? m_speed[k] + 1 : 15;
                            end
                        end
                    end
                    CRASH: begin
                        if (frame_tick) begin
                            m_hold[k]++;
                            if (m_hold[k] == hold_p[k]) m_st[k] = OVER;
                        end
                    end
                    OVER: begin
                        if (start) begin
                            m_st[k] = RUN; m_score[k] = 0; m_div[k] = 0; m_speed[k] = 1;
                        end
                    end
                    default: m_st[k] = IDLE;
                endcase
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            scroll_cnt0 = scroll_cnt0 + int'(sp[0]);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d status", k), 16'(gs[k]), 16'(m_st[k] == RUN));
                chk($sformatf("u%0d crashed", k), 16'(cr[k]), 16'((m_st[k] == CRASH) || (m_st[k] == OVER)));
                chk($sformatf("u%0d scroll", k), 16'(sp[k]), 16'(m_scroll[k]));
                chk($sformatf("u%0d speed", k), 16'(spd[k]), 16'(m_speed[k]));
                chk($sformatf("u%0d score", k), sc[k], to_bcd(m_score[k]));
                chk($sformatf("u%0d hi", k), hi[k], to_bcd(m_hi[k]));
                chk($sformatf("u%0d state", k), 16'(st[k]), 16'(m_st[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic t, input logic c);
        start = s; frame_tick = t; collision = c;
        @(negedge clk); #1;
    endtask

    task automatic ticks(input int n, input bit dense);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (!dense) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
            end
        end
        start = 1'b0; frame_tick = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset status", 16'(gs[0]), 16'h0);
        chk("reset speed", 16'(spd[0]), 16'd1);
        chk("reset score", sc[0], 16'h0000);
        chk("reset hi", hi[0], 16'h0000);

        // Idle: ticks without start do nothing.
        scroll_cnt0 = 0;
        ticks(5, 1'b0);
        chk("idle scrolls", 16'(scroll_cnt0), 16'd0);
        chk("idle status", 16'(gs[0]), 16'h0);
        chk("idle score", sc[0], 16'h0000);

        // Game 1: 12 frames then crash at 42.
        step(1'b1, 1'b0, 1'b0);
        chk("start status", 16'(gs[0]), 16'h1);
        scroll_cnt0 = 0;
        ticks(12, 1'b0);
        chk("run scrolls", 16'(scroll_cnt0), 16'd12);
        chk("run score", sc[0], 16'h0002);
        chk("run fast score", sc[1], 16'h0012);
        chk("run speed", 16'(spd[0]), 16'd1);
        ticks(240, 1'b0);
        chk("pre-crash score", sc[0], 16'h0042);
        step(1'b0, 1'b1, 1'b1);
        chk("crash scroll", 16'(sp[0]), 16'h0);
        chk("crash score", sc[0], 16'h0042);
        chk("crash hi", hi[0], 16'h0042);
        chk("crash crashed", 16'(cr[0]), 16'h1);
        chk("crash fast hi", hi[1], 16'h0252);
        step(1'b1, 1'b0, 1'b0);
        chk("start in hold", 16'(st[0]), 16'(CRASH));
        ticks(60, 1'b0);
        chk("over state", 16'(st[0]), 16'(OVER));
        chk("over fast state", 16'(st[1]), 16'(OVER));

        // Game 2: crash at 10, high score kept.
        step(1'b1, 1'b0, 1'b0);
        chk("restart score", sc[0], 16'h0000);
        chk("restart speed", 16'(spd[0]), 16'd1);
        chk("restart hi", hi[0], 16'h0042);
        ticks(60, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("game2 hi", hi[0], 16'h0042);
        chk("game2 fast hi", hi[1], 16'h0252);
        ticks(60, 1'b0);

        // Game 3: speed ramp, saturation and the 9999 wrap on the fast instance.
        step(1'b1, 1'b0, 1'b0);
        ticks(600, 1'b1);
        chk("ramp score", sc[0], 16'h0100);
        chk("ramp speed", 16'(spd[0]), 16'd2);
        chk("ramp fast speed", 16'(spd[1]), 16'd7);
        ticks(9399, 1'b1);
        chk("fast 9999", sc[1], 16'h9999);
        chk("fast sat speed", 16'(spd[1]), 16'd15);
        ticks(1, 1'b1);
        chk("wrap score", sc[1], 16'h0000);
        chk("wrap speed", 16'(spd[1]), 16'd15);
        chk("slow sat score", sc[0], 16'h1666);
        chk("slow sat speed", 16'(spd[0]), 16'd15);

        // Asynchronous reset between edges.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async status", 16'(gs[0]), 16'h0);
        chk("async speed", 16'(spd[0]), 16'd1);
        chk("async score", sc[0], 16'h0000);
        chk("async hi", hi[0], 16'h0000);
        chk("async fast score", sc[1], 16'h0000);
        @(negedge clk); #1 rst = 1'b0;

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level sequencer for the dinosaur game. Runs the game state machine (idle / run / crash / over), produces the `game_status` and `speed` that drive the Ground scroller, and issues one scroll strobe per video frame. Keeps a 4-digit BCD score and high score, and ramps speed with score. Sits between the input/collision logic and the Ground, obstacle and score-display blocks.

## Interface
Parameters:
- `SCORE_DIV`, default 6: frames per score point while running.
- `SPEED_MIN`, default 1: speed on game start.
- `SPEED_MAX`, default 15: speed ceiling; must be ≤ 15.
- `CRASH_HOLD`, default 60: frames spent in CRASH before start is accepted again.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: one-cycle pulse from the jump/start button, already debounced.
- `collision` in 1: level; dinosaur overlaps an obstacle.
- `game_status` out 1: 1 in RUN, else 0.
- `speed` out 4: scroll pixels per frame, handed to Ground.
- `scroll_pulse` out 1: one-cycle strobe; Ground advances by `speed`.
- `crashed` out 1: 1 in CRASH and OVER.
- `score` out 16: 4-digit packed BCD.
- `hi_score` out 16: 4-digit packed BCD.

## Operation
- The state machine has four states: IDLE, RUN, CRASH, OVER.
- **IDLE**:
  - On `start`, go to RUN.
  - Clear `score`, the frame divider and the hold counter.
  - Set `speed` to SPEED_MIN.
- **RUN**:
  - `collision` = 1 → go to CRASH. Collision has priority over a `frame_tick` in the same cycle: no scroll, no score change.
  - Otherwise, on each `frame_tick`:
    - assert `scroll_pulse`;
    - increment the frame divider, which counts 0..SCORE_DIV-1 and then wraps.
  - On the wrap, `score` += 1 in BCD. Each digit counts 0–9 with a carry. 9999 wraps to 0000.
  - When the increment makes the low two digits 00 (every 100 points, including the 9999→0000 wrap), `speed` += 1, saturating at SPEED_MAX.
  - `start` is ignored in RUN.
- **CRASH**:
  - On entry:
    - clear the hold counter;
    - if `score` > `hi_score`, copy `score` into `hi_score`. Use an unsigned compare on the 16 bits; packed BCD order equals numeric order.
  - Count `frame_tick`s. After CRASH_HOLD ticks, go to OVER.
  - `start` is ignored in CRASH.
- **OVER**:
  - On `start`, go to RUN with `score` = 0, divider = 0, `speed` = SPEED_MIN.
  - `hi_score` is kept.
- `collision` outside RUN is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - `game_status` = 0, `crashed` = 0, `scroll_pulse` = 0;
  - `speed` = SPEED_MIN;
  - `score` = 0000, `hi_score` = 0000.
- Reset asserted mid-game returns to IDLE immediately. `hi_score` is cleared too.
- All outputs are registered.
- Latencies:
  - `start` at cycle N → state RUN and `game_status` = 1 at N+1.
  - `frame_tick` at N in RUN → `scroll_pulse` = 1 at N+1 for exactly one cycle. `speed` at N+1 is the value Ground uses.
  - A score increment is visible at N+1. A speed increment caused by that score is also visible at N+1; it applies from the next scroll.
  - `collision` at N in RUN → `game_status` = 0 and `crashed` = 1 at N+1. `hi_score` is updated at N+1.
- `scroll_pulse` never asserts outside RUN.
- `start` and `frame_tick` in the same cycle in IDLE/OVER: enter RUN, no scroll that cycle.

## Structure
- Shared package `dino_pkg` holds:
  - the `game_state_t` enum (IDLE, RUN, CRASH, OVER);
  - `SPEED_W` = 4;
  - `BCD_DIGITS` = 4.
  Ground and the display block import it.
- One sub-module, `bcd4_counter`:
  - inputs: clear, increment enable;
  - outputs: the 16-bit packed BCD value and a `hundred_roll` flag, asserted when an increment produces low digits 00.
- The state machine, frame divider, hold counter, speed register and high-score register live in `game_ctrl`.

## Test plan
- **Reset/idle:** reset, then 5 `frame_tick`s with no `start` → `game_status` = 0, no `scroll_pulse`, `speed` = 1, `score` = 0000.
- **Run/score:** `start`, then 12 `frame_tick`s (SCORE_DIV = 6) → 12 single-cycle `scroll_pulse`s, `score` = 0002, `speed` = 1.
- **Speed ramp/saturation:** run 600 frames → `score` = 0100 and `speed` = 2. Preload `score` = 1399 with `speed` at 15 and force the next increment → `speed` stays 15.
- **Crash priority:** `collision` and `frame_tick` in the same cycle at `score` 0042 → no `scroll_pulse`, `score` stays 0042, `hi_score` = 0042, `crashed` = 1 next cycle.
- **Crash hold/restart:**
  - `start` during the 60-frame hold → ignored.
  - After 60 ticks, state is OVER.
  - `start` → RUN, `score` = 0000, `speed` = 1, `hi_score` = 0042.
  - A second game crashing at `score` 0010 → `hi_score` stays 0042.
- **Wrap/async reset:**
  - Preload `score` = 9999 and increment → 0000; `hundred_roll` drives a speed increment.
  - Assert `rst` mid-RUN between clock edges → outputs reach their reset values without waiting for a clock edge.
